// File: rtl/mix_pkg.sv
// Shared definitions for the voice mixer: FSM encoding and signed-range helpers.
package mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic longint MAX_S(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint MIN_S(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/mix_narrow.sv
// Narrows the guard-bit sum to WIDTH and flags overflow.
// Build option VOICE_MIX_SATURATE_EN clips on overflow; otherwise the low bits wrap.
module mix_narrow
    import mix_pkg::*;
#(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned AW    = 21
) (
    input  logic signed [AW-1:0]    i_sum,
    output logic        [WIDTH-1:0] o_data_c,
    output logic                    o_overflow_c
);

    localparam logic signed [AW-1:0] C_MAX = AW'(MAX_S(WIDTH));
    localparam logic signed [AW-1:0] C_MIN = AW'(MIN_S(WIDTH));

    logic w_over_hi;
    logic w_over_lo;

    assign w_over_hi    = (i_sum > C_MAX);
    assign w_over_lo    = (i_sum < C_MIN);
    assign o_overflow_c = w_over_hi | w_over_lo;

`ifdef VOICE_MIX_SATURATE_EN
    always_comb begin
        o_data_c = i_sum[WIDTH-1:0];
        if (w_over_hi) o_data_c = C_MAX[WIDTH-1:0];
        if (w_over_lo) o_data_c = C_MIN[WIDTH-1:0];
    end
`else
    assign o_data_c = i_sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/voice_mix_accumulator.sv
// Sums a frame of signed voice samples from a valid/ready stream into one mixed sample.
// Saturation on overflow is selected by VOICE_MIX_SATURATE_EN (see mix_narrow).
module voice_mix_accumulator
    import mix_pkg::*;
#(
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned VOICES = 8,
    parameter int unsigned GUARD  = clog2(VOICES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_overflow,
    output logic             m_truncated,
    output logic [GUARD:0]   m_count
);

    localparam int unsigned AW = WIDTH + GUARD;
    localparam int unsigned CW = GUARD + 1;

    state_t           r_state;
    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_count;
    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;
    logic             r_m_overflow;
    logic             r_m_truncated;
    logic [CW-1:0]    r_m_count;

    logic             w_accept;
    logic [AW-1:0]    w_data_ext;
    logic [AW-1:0]    w_sum;
    logic [CW-1:0]    w_count_next;
    logic             w_full;
    logic             w_frame_end;
    logic [WIDTH-1:0] w_narrow_data;
    logic             w_narrow_ovf;

    assign s_ready     = (r_state != ST_HOLD);
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign m_overflow  = r_m_overflow;
    assign m_truncated = r_m_truncated;
    assign m_count     = r_m_count;

    // Running sum including the beat being offered; the first beat of a frame seeds it.
    assign w_accept     = s_valid && s_ready;
    assign w_data_ext   = {{GUARD{s_data[WIDTH-1]}}, s_data};
    assign w_sum        = (r_state == ST_IDLE) ? w_data_ext : r_acc + w_data_ext;
    assign w_count_next = (r_state == ST_IDLE) ? CW'(1) : r_count + CW'(1);
    assign w_full       = (w_count_next == CW'(VOICES));
    assign w_frame_end  = s_last || w_full;

    mix_narrow #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_narrow (
        .i_sum        (w_sum),
        .o_data_c     (w_narrow_data),
        .o_overflow_c (w_narrow_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_acc         <= '0;
            r_count       <= '0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_overflow  <= 1'b0;
            r_m_truncated <= 1'b0;
            r_m_count     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_sum;
                        r_count <= w_count_next;
                        r_state <= ST_ACCUM;
                        if (w_frame_end) begin
                            r_m_valid     <= 1'b1;
                            r_m_data      <= w_narrow_data;
                            r_m_overflow  <= w_narrow_ovf;
                            r_m_truncated <= w_full && !s_last;
                            r_m_count     <= w_count_next;
                            r_state       <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result stays frozen until downstream takes it.
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mix_accumulator.sv
// Self-checking bench for voice_mix_accumulator: directed cases plus random frames
// checked against an arithmetic frame model.
module tb_voice_mix_accumulator;

    localparam int unsigned WIDTH  = 18;
    localparam int unsigned VOICES = 8;
    localparam int unsigned GUARD  = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_overflow;
    logic             m_truncated;
    logic [GUARD:0]   m_count;

    int     n_vec = 0;
    int     n_err = 0;
    longint mdl_sum;
    int     mdl_cnt;
    longint e_data;
    int     e_cnt;
    int     e_ovf;
    int     e_trunc;

    voice_mix_accumulator #(.WIDTH(WIDTH), .VOICES(VOICES)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_overflow  (m_overflow),
        .m_truncated (m_truncated),
        .m_count     (m_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint half_range();
        return longint'(1) <<< (WIDTH - 1);
    endfunction

    // Expected output sample for a full-precision sum.
    function automatic longint exp_data(input longint sum);
        longint half;
        longint full;
        longint r;
        half = half_range();
        full = half * 2;
`ifdef VOICE_MIX_SATURATE_EN
        r = sum;
        if (sum > half - 1) r = half - 1;
        if (sum < -half) r = -half;
`else
        r = (sum + half) % full;
        if (r < 0) r = r + full;
        r = r - half;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and wait (bounded) until it is accepted.
    task automatic beat(input longint d, input bit last);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = WIDTH'(d);
        s_last  = last;
        while (!s_ready && t < 50) begin
            tick();
            t++;
        end
        check("s_ready_wait", s_ready, 1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic check_result(input string tag);
        check({tag, "_valid"}, m_valid, 1);
        check({tag, "_data"}, $signed(m_data), e_data);
        check({tag, "_count"}, m_count, e_cnt);
        check({tag, "_ovf"}, m_overflow, e_ovf);
        check({tag, "_trunc"}, m_truncated, e_trunc);
        check({tag, "_sready"}, s_ready, 0);
    endtask

    // Stall downstream for some cycles (optionally offering junk input), then take the result.
    task automatic handshake(input int stall, input bit junk);
        if (junk) begin
            s_valid = 1'b1;
            s_data  = WIDTH'(999);
            s_last  = 1'b1;
        end
        repeat (stall) begin
            tick();
            check_result("hold");
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("release_valid", m_valid, 0);
        check("release_sready", s_ready, 1);
    endtask

    // Send a beat through the model; on frame end, check the result and drain it.
    task automatic mbeat(input longint d, input bit last, input int stall, input bit junk);
        beat(d, last);
        mdl_sum = mdl_sum + d;
        mdl_cnt++;
        if (last || mdl_cnt == int'(VOICES)) begin
            e_data  = exp_data(mdl_sum);
            e_cnt   = mdl_cnt;
            e_ovf   = (mdl_sum > half_range() - 1 || mdl_sum < -half_range()) ? 1 : 0;
            e_trunc = (!last) ? 1 : 0;
            check_result("frame");
            handshake(stall, junk);
            mdl_sum = 0;
            mdl_cnt = 0;
        end else begin
            check("mid_valid", m_valid, 0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        mdl_sum = 0;
        mdl_cnt = 0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_count", m_count, 0);
        check("rst_ovf", m_overflow, 0);
        check("rst_trunc", m_truncated, 0);
        check("rst_sready", s_ready, 1);

        // Basic frame, then backpressure with junk input during hold.
        mbeat(100, 0, 0, 0);
        mbeat(200, 0, 0, 0);
        mbeat(-50, 1, 5, 1);

        // Overflow in both directions.
        mbeat(131071, 0, 0, 0);
        mbeat(1, 1, 1, 0);
        mbeat(-131072, 0, 0, 0);
        mbeat(-1, 1, 0, 0);

        // Single-beat frame.
        mbeat(-12345, 1, 0, 0);

        // Truncation: eight beats without last, ninth forms its own frame.
        for (int i = 0; i < 8; i++) mbeat(1000, 0, 0, 0);
        mbeat(1000, 1, 0, 0);

        // Exactly VOICES beats with last on the final one is not truncated.
        for (int i = 0; i < 8; i++) mbeat(longint'(i) * 7 - 20, (i == 7), 0, 0);

        // Reset mid-frame discards the partial sum.
        beat(500, 0);
        beat(600, 0);
        check("mid_rst_valid", m_valid, 0);
        reset_n = 1'b0;
        #3;
        check("in_rst_valid", m_valid, 0);
        check("in_rst_sready", s_ready, 1);
        reset_n = 1'b1;
        tick();
        mdl_sum = 0;
        mdl_cnt = 0;
        mbeat(7, 1, 0, 0);

        // Randomised frames, mixing small and full-range samples.
        for (int f = 0; f < 40; f++) begin
            int  len;
            bit  wide;
            len  = int'($urandom_range(1, VOICES + 2));
            wide = $urandom_range(0, 1) == 1;
            for (int i = 0; i < len; i++) begin
                longint d;
                if (wide) d = longint'($urandom_range(0, (1 << WIDTH) - 1)) - half_range();
                else      d = longint'($urandom_range(0, 4000)) - 2000;
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
                mbeat(d, (i == len - 1), int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
